// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array tile scheduler.
// Latency: n/a (package). Backpressure: n/a.
// Holds state encodings, the tile-size ceiling, read-select codes and the config check.
package sa_pkg;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE   = 3'd0;
    localparam sched_state_t S_RD_WGT = 3'd1;
    localparam sched_state_t S_RD_SRC = 3'd2;
    localparam sched_state_t S_COMP   = 3'd3;
    localparam sched_state_t S_WR     = 3'd4;
    localparam sched_state_t S_NEXT   = 3'd5;
    localparam sched_state_t S_FAIL   = 3'd6;

    localparam logic [10:0] MAX_BLK_BYTES = 11'd1024;

    localparam logic RD_SEL_WGT = 1'b0;
    localparam logic RD_SEL_SRC = 1'b1;

    // Tiles must be whole 32-bit words and fit the engine buffer.
    function automatic logic blk_bytes_bad(input logic [10:0] b);
        return (b == 11'd0) || (b[1:0] != 2'b00) || (b > MAX_BLK_BYTES);
    endfunction

endpackage

// File: rtl/sa_sched_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry one count short of all-ones.
// Latency: expire is combinational from the count register. Backpressure: none.
// Clear dominates enable so each new wait state starts from zero.
module sa_sched_watchdog #(
    parameter int TO_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam logic [TO_W-1:0] LAST_CNT = {{(TO_W-1){1'b1}}, 1'b0};

    logic [TO_W-1:0] r_cnt;

    // The increment that would reach all-ones is the one that fires.
    assign o_expire = i_en && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer: per tile issues weight read, activation read, engine start, write; optional watchdog SA_SCHED_TIMEOUT_EN.
// Latency: start edge -> first command 1 cycle; done pulse -> next command 1 cycle (+1 between tiles).
// Backpressure: none; each step waits indefinitely for its completion pulse unless the watchdog is built in.
module sa_tile_scheduler
    import sa_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 16,
    parameter int TO_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_wgt_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [10:0]       i_blk_bytes,
    input  logic [BLK_W-1:0]  i_num_blk,
    input  logic              i_wgt_reuse,
    output logic              o_rd_start,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_sel,
    output logic [7:0]        o_num_trans,
    input  logic              i_rd_done,
    input  logic              i_wr_done,
    input  logic              i_eng_done,
    input  logic              i_wr_err,
    input  logic              i_eng_err,
    output logic              o_eng_start,
    output logic              o_wr_start,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [BLK_W-1:0]  o_blk_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);

    sched_state_t      r_state, w_nxt;
    logic              r_start_d, r_reuse;
    logic [ADDR_W-1:0] r_src_ptr, r_wgt_ptr, r_dst_ptr;
    logic [10:0]       r_blk_bytes;
    logic [BLK_W-1:0]  r_num_blk, r_blk_idx;
    logic              r_rd_start, r_rd_sel, r_eng_start, r_wr_start;
    logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
    logic [7:0]        r_num_trans;
    logic              r_busy, r_done, r_error;
    logic              w_start_edge, w_cfg_bad, w_last, w_err, w_expire;
    logic [ADDR_W-1:0] w_inc;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_cfg_bad    = blk_bytes_bad(i_blk_bytes);
    assign w_last       = (r_blk_idx == r_num_blk - BLK_ONE);
    assign w_inc        = ADDR_W'(r_blk_bytes);
    assign w_err        = i_wr_err | i_eng_err | w_expire;

`ifdef SA_SCHED_TIMEOUT_EN
    logic w_waiting;
    assign w_waiting = r_state inside {S_RD_WGT, S_RD_SRC, S_COMP, S_WR};

    sa_sched_watchdog #(.TO_W(TO_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_waiting),
        .i_clr    ((w_nxt != r_state) | ~w_waiting),
        .o_expire (w_expire)
    );
`else
    // Without the watchdog nothing can expire; a zero-width counter is the only degenerate case.
    assign w_expire = (TO_W == 0);
`endif

    // Completions in the command cycle itself are too early and are dropped.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    if (w_cfg_bad)            w_nxt = S_FAIL;
                    else if (i_num_blk != '0) w_nxt = S_RD_WGT;
                end
            end
            S_RD_WGT: if (w_err) w_nxt = S_FAIL;
                      else if (i_rd_done && !r_rd_start) w_nxt = S_RD_SRC;
            S_RD_SRC: if (w_err) w_nxt = S_FAIL;
                      else if (i_rd_done && !r_rd_start) w_nxt = S_COMP;
            S_COMP:   if (w_err) w_nxt = S_FAIL;
                      else if (i_eng_done && !r_eng_start) w_nxt = S_WR;
            S_WR:     if (w_err) w_nxt = S_FAIL;
                      else if (i_wr_done && !r_wr_start) w_nxt = S_NEXT;
            S_NEXT:   if (w_err) w_nxt = S_FAIL;
                      else if (w_last) w_nxt = S_IDLE;
                      else w_nxt = r_reuse ? S_RD_SRC : S_RD_WGT;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b0;
            r_reuse     <= 1'b0;
            r_src_ptr   <= '0;
            r_wgt_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_blk_bytes <= '0;
            r_num_blk   <= '0;
            r_blk_idx   <= '0;
            r_rd_start  <= 1'b0;
            r_rd_sel    <= RD_SEL_WGT;
            r_rd_addr   <= '0;
            r_num_trans <= '0;
            r_eng_start <= 1'b0;
            r_wr_start  <= 1'b0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_start_d   <= i_start;
            r_rd_start  <= 1'b0;
            r_eng_start <= 1'b0;
            r_wr_start  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;

            if (r_state == S_IDLE && w_start_edge) begin
                r_src_ptr   <= i_src_addr;
                r_wgt_ptr   <= i_wgt_addr;
                r_dst_ptr   <= i_dst_addr;
                r_blk_bytes <= i_blk_bytes;
                r_num_blk   <= i_num_blk;
                r_reuse     <= i_wgt_reuse;
                r_num_trans <= i_blk_bytes[9:2];
                r_blk_idx   <= '0;
                r_done      <= ~w_cfg_bad && (i_num_blk == '0);
            end

            // Pointers step as the write completes so they are ready when NEXT picks the next read.
            if (r_state == S_WR && w_nxt == S_NEXT) begin
                r_src_ptr <= r_src_ptr + w_inc;
                r_dst_ptr <= r_dst_ptr + w_inc;
                if (!r_reuse) r_wgt_ptr <= r_wgt_ptr + w_inc;
            end
            if (r_state == S_NEXT && w_nxt != S_FAIL) r_blk_idx <= r_blk_idx + BLK_ONE;

            if (w_nxt != r_state) begin
                case (w_nxt)
                    S_RD_WGT: begin
                        r_rd_start <= 1'b1;
                        r_rd_sel   <= RD_SEL_WGT;
                        r_rd_addr  <= (r_state == S_IDLE) ? i_wgt_addr : r_wgt_ptr;
                        r_busy     <= 1'b1;
                    end
                    S_RD_SRC: begin
                        r_rd_start <= 1'b1;
                        r_rd_sel   <= RD_SEL_SRC;
                        r_rd_addr  <= r_src_ptr;
                    end
                    S_COMP: r_eng_start <= 1'b1;
                    S_WR: begin
                        r_wr_start <= 1'b1;
                        r_wr_addr  <= r_dst_ptr;
                    end
                    S_FAIL: begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    S_IDLE: if (r_state == S_NEXT) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_start  = r_rd_start;
    assign o_rd_addr   = r_rd_addr;
    assign o_rd_sel    = r_rd_sel;
    assign o_num_trans = r_num_trans;
    assign o_eng_start = r_eng_start;
    assign o_wr_start  = r_wr_start;
    assign o_wr_addr   = r_wr_addr;
    assign o_blk_idx   = r_blk_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler: a responder answers commands while a scoreboard of expected commands is popped.
module tb_sa_tile_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_start, i_wgt_reuse;
    logic [31:0] i_src_addr, i_wgt_addr, i_dst_addr;
    logic [10:0] i_blk_bytes;
    logic [15:0] i_num_blk;
    logic        i_rd_done, i_wr_done, i_eng_done, i_wr_err, i_eng_err;
    logic        o_rd_start, o_rd_sel, o_eng_start, o_wr_start, o_busy, o_done, o_error;
    logic [31:0] o_rd_addr, o_wr_addr;
    logic [7:0]  o_num_trans;
    logic [15:0] o_blk_idx;

    int n_checks = 0;
    int n_err    = 0;

    logic [32:0] q_rd[$];
    logic [31:0] q_wr[$];

    sa_tile_scheduler dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_src_addr(i_src_addr), .i_wgt_addr(i_wgt_addr), .i_dst_addr(i_dst_addr),
        .i_blk_bytes(i_blk_bytes), .i_num_blk(i_num_blk), .i_wgt_reuse(i_wgt_reuse),
        .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr), .o_rd_sel(o_rd_sel), .o_num_trans(o_num_trans),
        .i_rd_done(i_rd_done), .i_wr_done(i_wr_done), .i_eng_done(i_eng_done),
        .i_wr_err(i_wr_err), .i_eng_err(i_eng_err),
        .o_eng_start(o_eng_start), .o_wr_start(o_wr_start), .o_wr_addr(o_wr_addr),
        .o_blk_idx(o_blk_idx), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ":pulses_busy_sel"}, {o_busy, o_rd_start, o_eng_start, o_wr_start, o_done, o_error, o_rd_sel}, 7'd0);
        chk({tag, ":blk_idx"}, o_blk_idx, 16'd0);
        chk({tag, ":rd_addr"}, o_rd_addr, 32'd0);
        chk({tag, ":wr_addr"}, o_wr_addr, 32'd0);
        chk({tag, ":num_trans"}, o_num_trans, 8'd0);
    endtask

    // err_tile >= 0 raises i_wr_err together with i_wr_done on that tile's write.
    task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] wgt,
                           input logic [31:0] dst, input logic [10:0] bytes, input logic [15:0] num,
                           input logic reuse, input int err_tile, input bit rst_in_wr);
        bit bad, ended, inject;
        int tiles, rd_pend, eng_pend, wr_pend, n_eng, n_done, n_error, wr_seen;
        logic [15:0] exp_idx;
        logic [7:0]  exp_nt;
        bad = (bytes == 11'd0) || (bytes % 4 != 0) || (bytes > 11'd1024);
        tiles = bad ? 0 : ((err_tile >= 0) ? err_tile + 1 : int'(num));
        exp_idx = (bad || num == 16'd0) ? 16'd0 : ((err_tile >= 0) ? 16'(err_tile) : num);
        exp_nt = 8'(bytes / 4);
        ended = 0; inject = 0; rd_pend = 0; eng_pend = 0; wr_pend = 0;
        n_eng = 0; n_done = 0; n_error = 0; wr_seen = 0;
        q_rd.delete();
        q_wr.delete();
        for (int t = 0; t < tiles; t++) begin
            if (!reuse || t == 0) q_rd.push_back({1'b0, wgt + 32'(t) * 32'(bytes)});
            q_rd.push_back({1'b1, src + 32'(t) * 32'(bytes)});
            q_wr.push_back(dst + 32'(t) * 32'(bytes));
        end

        i_src_addr = src; i_wgt_addr = wgt; i_dst_addr = dst;
        i_blk_bytes = bytes; i_num_blk = num; i_wgt_reuse = reuse;
        i_start = 1'b1;
        for (int c = 1; c <= 600 && !ended; c++) begin
            @(negedge clk);
            i_rd_done = 0; i_eng_done = 0; i_wr_done = 0; i_wr_err = 0;
            if (rd_pend > 0) begin rd_pend--; if (rd_pend == 0) i_rd_done = 1; end
            if (eng_pend > 0) begin eng_pend--; if (eng_pend == 0) i_eng_done = 1; end
            if (wr_pend > 0) begin
                wr_pend--;
                if (wr_pend == 0) begin i_wr_done = 1; i_wr_err = inject; end
            end
            if (c == 1 && !bad && num != 16'd0)
                chk({name, ":first_rd_cycle1"}, {o_busy, o_rd_start, o_rd_sel}, 3'b110);
            if (o_rd_start) begin
                chk({name, ":rd_expected"}, q_rd.size() != 0, 1);
                if (q_rd.size() != 0) chk({name, ":rd_cmd"}, {o_rd_sel, o_rd_addr}, q_rd.pop_front());
                chk({name, ":num_trans"}, o_num_trans, exp_nt);
                rd_pend = 2;
            end
            if (o_eng_start) begin n_eng++; eng_pend = 3; end
            if (o_wr_start) begin
                chk({name, ":wr_expected"}, q_wr.size() != 0, 1);
                if (q_wr.size() != 0) chk({name, ":wr_cmd"}, o_wr_addr, q_wr.pop_front());
                if (rst_in_wr) begin
                    rst = 1'b1; i_start = 1'b0;
                    i_rd_done = 0; i_eng_done = 0; i_wr_done = 0; i_wr_err = 0;
                    @(negedge clk);
                    chk_reset_vals({name, ":rst_mid_wr"});
                    rst = 1'b0;
                    ended = 1;
                end else begin
                    inject = (wr_seen == err_tile);
                    wr_seen++;
                    wr_pend = 1;
                end
            end
            if (!rst_in_wr && (o_done || o_error)) begin
                n_done += int'(o_done);
                n_error += int'(o_error);
                chk({name, ":busy_low_at_end"}, o_busy, 1'b0);
                ended = 1;
            end
        end
        chk({name, ":ended"}, ended, 1'b1);
        if (!rst_in_wr) begin
            chk({name, ":rd_left"}, q_rd.size(), 0);
            chk({name, ":wr_left"}, q_wr.size(), 0);
            chk({name, ":eng_starts"}, n_eng, tiles);
            chk({name, ":done_pulses"}, n_done, (bad || err_tile >= 0) ? 0 : 1);
            chk({name, ":error_pulses"}, n_error, (bad || err_tile >= 0) ? 1 : 0);
            chk({name, ":blk_idx"}, o_blk_idx, exp_idx);
            // i_start is still high: no new edge, so the block must stay quiet.
            repeat (3) @(negedge clk);
            chk({name, ":quiet_after"}, {o_busy, o_rd_start, o_eng_start, o_wr_start, o_done, o_error}, 6'd0);
        end
        i_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; i_start = 0; i_wgt_reuse = 0;
        i_src_addr = 0; i_wgt_addr = 0; i_dst_addr = 0; i_blk_bytes = 0; i_num_blk = 0;
        i_rd_done = 0; i_wr_done = 0; i_eng_done = 0; i_wr_err = 0; i_eng_err = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        run_job("basic3",   32'h1000, 32'h2000, 32'h3000, 11'd64, 16'd3, 1'b0, -1, 0);
        run_job("reuse2",   32'h1000, 32'h2000, 32'h3000, 11'd64, 16'd2, 1'b1, -1, 0);
        run_job("bytes6",   32'h1000, 32'h2000, 32'h3000, 11'd6,  16'd2, 1'b0, -1, 0);
        run_job("bytes0",   32'h1000, 32'h2000, 32'h3000, 11'd0,  16'd2, 1'b0, -1, 0);
        run_job("bytes1028",32'h1000, 32'h2000, 32'h3000, 11'd1028, 16'd1, 1'b0, -1, 0);
        run_job("bytes1024",32'h1000, 32'h2000, 32'h3000, 11'd1024, 16'd1, 1'b0, -1, 0);
        run_job("num0",     32'h1000, 32'h2000, 32'h3000, 11'd64, 16'd0, 1'b0, -1, 0);
        run_job("wrerr_t1", 32'h1000, 32'h2000, 32'h3000, 11'd64, 16'd3, 1'b0, 1, 0);
        run_job("wrap",     32'hFFFF_FFC0, 32'h2000, 32'h3000, 11'd64, 16'd2, 1'b0, -1, 0);
        run_job("rst_wr",   32'h4000, 32'h5000, 32'h6000, 11'd32, 16'd2, 1'b0, -1, 1);
        run_job("recover",  32'h100, 32'h200, 32'h300, 11'd16, 16'd1, 1'b1, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_tile_scheduler.md
# sa_tile_scheduler

Block-level sequencer for the systolic-array datapath: steps through N tiles, issuing per-tile DMA read commands (weights, then activations), an engine start, and a DMA write command, advancing source/weight/destination addresses by a programmed stride. Sits between the AXI-Lite register file and the DMA read/write movers plus engine, replacing the fixed single-block control path. Reports busy/done/error and the current tile index to software.

## Interface
- ADDR_W, 32, address width of all base/stride/command addresses
- BLK_W, 16, width of tile count and tile index
- TO_W, 20, watchdog counter width (used only with SA_SCHED_TIMEOUT_EN)
- clk  in  1  sole clock; every input sampled and every output driven on its rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  level; rising edge starts a job
- i_src_addr / i_wgt_addr / i_dst_addr  in  ADDR_W each  base addresses, latched at start
- i_blk_bytes  in  11  bytes per tile, latched at start
- i_num_blk  in  BLK_W  tile count, latched at start
- i_wgt_reuse  in  1  1 = fetch weights for tile 0 only
- o_rd_start  out  1  one-cycle read command pulse
- o_rd_addr  out  ADDR_W  read address, held stable from o_rd_start until i_rd_done
- o_rd_sel  out  1  0 = weight read, 1 = activation read
- o_num_trans  out  8  words per transfer = blk_bytes[9:2]
- i_rd_done / i_wr_done / i_eng_done  in  1  single-cycle completion pulses
- i_wr_err / i_eng_err  in  1  single-cycle error pulses
- o_eng_start  out  1  one-cycle engine start pulse
- o_wr_start  out  1  one-cycle write command pulse
- o_wr_addr  out  ADDR_W  write address, held stable until i_wr_done
- o_blk_idx  out  BLK_W  current tile index
- o_busy / o_done / o_error  out  1  status; o_done, o_error are one-cycle pulses

## Operation
- States: IDLE, RD_WGT, RD_SRC, COMP, WR, NEXT, FAIL.
- IDLE: rising edge of i_start latches configuration and clears o_blk_idx. Invalid config (blk_bytes 0, not multiple of 4, or > 1024) -> FAIL. i_num_blk == 0 -> o_done pulse, stay IDLE. Otherwise -> RD_WGT, or RD_SRC when i_wgt_reuse and blk_idx != 0.
- RD_WGT: pulse o_rd_start (o_rd_sel=0, addr = wgt_ptr) on entry; on i_rd_done -> RD_SRC.
- RD_SRC: pulse o_rd_start (o_rd_sel=1, addr = src_ptr); on i_rd_done -> COMP.
- COMP: pulse o_eng_start on entry; on i_eng_done -> WR.
- WR: pulse o_wr_start (addr = dst_ptr); on i_wr_done -> NEXT.
- NEXT: src_ptr, dst_ptr += blk_bytes; wgt_ptr += blk_bytes unless reuse; blk_idx++. blk_idx == num_blk-1 before increment -> o_done pulse, IDLE; else -> RD_WGT/RD_SRC per reuse rule.
- Pointer arithmetic modulo 2^ADDR_W (wrap silently, no error).
- i_wr_err or i_eng_err in any non-IDLE state -> FAIL; error takes priority over a coincident done pulse.
- FAIL: o_error pulse one cycle, -> IDLE. o_blk_idx retains failing tile.
- i_start edges while o_busy=1 ignored; done pulses arriving in unrelated states ignored.

## Timing
- Reset: state IDLE, all pulses 0, o_busy 0, o_blk_idx 0, o_rd_addr/o_wr_addr 0, o_rd_sel 0, o_num_trans 0.
- Start edge sampled cycle 0 -> o_busy=1 and first o_rd_start at cycle 1.
- Command pulse exactly one cycle after state entry; completion pulse accepted no earlier than the cycle after the command.
- Done pulse -> next command 1 cycle later (NEXT costs one extra cycle between tiles).
- o_busy falls in the same cycle o_done or o_error is asserted.
- rst mid-job: immediate return to reset values; outstanding downstream commands are not cancelled (downstream reset together).

## Configuration
- SA_SCHED_TIMEOUT_EN defined: watchdog counts cycles in RD_WGT/RD_SRC/COMP/WR, clears on each state change; reaching 2^TO_W-1 -> FAIL.
- Undefined: no watchdog; scheduler waits indefinitely for completion pulses.

## Structure
- sa_pkg: sched state enum, MAX_BLK_BYTES (1024), rd_sel encodings.
- One sub-module: sa_sched_watchdog (counter, clear, expire flag), instantiated only under SA_SCHED_TIMEOUT_EN.

## Test plan
- num_blk=3, blk_bytes=64, reuse=0, src=0x1000, wgt=0x2000, dst=0x3000 -> 6 reads, 3 engine starts, writes at 0x3000/0x3040/0x3080, one o_done, o_num_trans=16.
- reuse=1, num_blk=2 -> exactly one weight read (0x2000), two activation reads, o_done.
- blk_bytes=6 or 0 -> o_error pulse, no commands issued; num_blk=0 -> o_done only.
- i_wr_err coincident with i_wr_done on tile 1 -> o_error, no o_done, o_blk_idx=1.
- src=0xFFFF_FFC0, blk_bytes=64, num_blk=2 -> second read at 0x0000_0000.
- With SA_SCHED_TIMEOUT_EN, TO_W=4, withhold i_eng_done -> o_error 15 cycles after COMP entry; rst mid-WR -> all outputs at reset values next cycle.
